// File: rtl/unary_bounds_decoder.sv
// rtl/unary_bounds_decoder.sv - unary bitstream sink: running count bounds and binary result (optional threshold decision: UNARY_DECODE_THRESHOLD_EN)
module unary_bounds_decoder #(
  parameter int INPUT_WIDTH = 32,
  parameter int COUNT_WIDTH = $clog2(INPUT_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [COUNT_WIDTH-1:0] threshold_i,
  input  logic                   in_valid_i,
  input  logic                   in_bit_i,
  output logic                   in_ready_o,
  output logic [COUNT_WIDTH-1:0] lower_bound_o,
  output logic [COUNT_WIDTH-1:0] upper_bound_o,
  output logic                   busy_o,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [COUNT_WIDTH-1:0] result_o,
  output logic                   decision_valid_o,
  output logic                   decision_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] WIDTH_C = COUNT_WIDTH'(INPUT_WIDTH);
  localparam logic [COUNT_WIDTH-1:0] LAST_C  = COUNT_WIDTH'(INPUT_WIDTH - 1);

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] ones_q, ones_d;
  logic [COUNT_WIDTH-1:0] bits_q, bits_d;
  logic                   xfer;
  logic                   start_ok;

  assign xfer     = (state_q == S_COLLECT) && in_valid_i;
  assign start_ok = (state_q == S_IDLE) && start_i;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the last accepted bit moves to DONE, the result handshake returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (start_i) state_d = S_COLLECT;
      S_COLLECT: if (xfer && (bits_q == LAST_C)) state_d = S_DONE;
      S_DONE:    if (result_ready_i) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Counter next values: cleared on accepted start, advanced on each transfer, held otherwise
  always_comb begin
    ones_d = ones_q;
    bits_d = bits_q;
    if (start_ok) begin
      ones_d = '0;
      bits_d = '0;
    end else if (xfer) begin
      ones_d = ones_q + COUNT_WIDTH'(in_bit_i);
      bits_d = bits_q + 1'b1;
    end
  end

  // Counter registers; a reset discards any partial stream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ones_q <= '0;
      bits_q <= '0;
    end else begin
      ones_q <= ones_d;
      bits_q <= bits_d;
    end
  end

  // Bounds never exceed INPUT_WIDTH, so the wrap of the intermediate difference is harmless
  assign lower_bound_o = ones_q;
  assign upper_bound_o = WIDTH_C - bits_q + ones_q;

`ifdef UNARY_DECODE_THRESHOLD_EN
  logic [COUNT_WIDTH-1:0] thr_q;

  // Threshold is captured only when a start is accepted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      thr_q <= '0;
    end else if (start_ok) begin
      thr_q <= threshold_i;
    end
  end
`else
  logic unused_threshold;
  assign unused_threshold = ^threshold_i;
`endif

  // Outputs decoded from the state; the decision is sticky because lower only rises and upper only falls
  always_comb begin
    in_ready_o       = (state_q == S_COLLECT);
    busy_o           = (state_q != S_IDLE);
    result_valid_o   = (state_q == S_DONE);
    result_o         = (state_q == S_DONE) ? ones_q : '0;
    decision_valid_o = 1'b0;
    decision_o       = 1'b0;
`ifdef UNARY_DECODE_THRESHOLD_EN
    if (state_q != S_IDLE) begin
      if (lower_bound_o >= thr_q) begin
        decision_valid_o = 1'b1;
        decision_o       = 1'b1;
      end else if (upper_bound_o < thr_q) begin
        decision_valid_o = 1'b1;
        decision_o       = 1'b0;
      end
    end
`endif
  end

endmodule

// File: tb/tb_unary_bounds_decoder.sv
// tb/tb_unary_bounds_decoder.sv - self-checking bench for unary_bounds_decoder
module tb_unary_bounds_decoder;

  localparam int W  = 32;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start_i = 1'b0;
  logic [CW-1:0] threshold_i = '0;
  logic          in_valid_i = 1'b0;
  logic          in_bit_i = 1'b0;
  logic          in_ready_o;
  logic [CW-1:0] lower_bound_o;
  logic [CW-1:0] upper_bound_o;
  logic          busy_o;
  logic          result_valid_o;
  logic          result_ready_i = 1'b0;
  logic [CW-1:0] result_o;
  logic          decision_valid_o;
  logic          decision_o;

  int tests = 0;
  int fails = 0;
  int m_ones = 0;
  int m_bits = 0;
  int m_thr = 0;

  unary_bounds_decoder #(.INPUT_WIDTH(W)) dut (
    .clk              (clk),
    .reset            (reset),
    .start_i          (start_i),
    .threshold_i      (threshold_i),
    .in_valid_i       (in_valid_i),
    .in_bit_i         (in_bit_i),
    .in_ready_o       (in_ready_o),
    .lower_bound_o    (lower_bound_o),
    .upper_bound_o    (upper_bound_o),
    .busy_o           (busy_o),
    .result_valid_o   (result_valid_o),
    .result_ready_i   (result_ready_i),
    .result_o         (result_o),
    .decision_valid_o (decision_valid_o),
    .decision_o       (decision_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Idle-state outputs, with bounds frozen at the last transaction's values
  task automatic check_idle(input string tag, input int lo, input int up);
    check({tag, "_busy"}, int'(busy_o), 0);
    check({tag, "_in_ready"}, int'(in_ready_o), 0);
    check({tag, "_rvalid"}, int'(result_valid_o), 0);
    check({tag, "_result"}, int'(result_o), 0);
    check({tag, "_lower"}, int'(lower_bound_o), lo);
    check({tag, "_upper"}, int'(upper_bound_o), up);
    check({tag, "_dvalid"}, int'(decision_valid_o), 0);
    check({tag, "_dec"}, int'(decision_o), 0);
  endtask

  // In-flight outputs from the reference counts
  task automatic check_busy(input string tag);
    int exp_dv;
    int exp_dec;
    exp_dv  = 0;
    exp_dec = 0;
`ifdef UNARY_DECODE_THRESHOLD_EN
    if (m_ones >= m_thr) begin
      exp_dv  = 1;
      exp_dec = 1;
    end else if (W - m_bits + m_ones < m_thr) begin
      exp_dv = 1;
    end
`endif
    check({tag, "_busy"}, int'(busy_o), 1);
    check({tag, "_lower"}, int'(lower_bound_o), m_ones);
    check({tag, "_upper"}, int'(upper_bound_o), W - m_bits + m_ones);
    check({tag, "_in_ready"}, int'(in_ready_o), (m_bits < W) ? 1 : 0);
    check({tag, "_rvalid"}, int'(result_valid_o), (m_bits == W) ? 1 : 0);
    check({tag, "_result"}, int'(result_o), (m_bits == W) ? m_ones : 0);
    check({tag, "_dvalid"}, int'(decision_valid_o), exp_dv);
    check({tag, "_dec"}, int'(decision_o), exp_dec);
  endtask

  task automatic start_txn(input int thr);
    start_i = 1'b1;
    threshold_i = CW'(thr);
    tick();
    start_i = 1'b0;
    threshold_i = CW'($urandom);
    m_ones = 0;
    m_bits = 0;
    m_thr = thr;
    check_busy("start");
  endtask

  // Optional idle cycles with garbage on in_bit, then one transfer
  task automatic send_bit(input logic b, input int gap);
    for (int g = 0; g < gap; g++) begin
      in_valid_i = 1'b0;
      in_bit_i = 1'($urandom);
      tick();
      check_busy("gap");
    end
    in_valid_i = 1'b1;
    in_bit_i = b;
    tick();
    in_valid_i = 1'b0;
    m_bits++;
    m_ones += int'(b);
    check_busy("bit");
  endtask

  // Hold the result for 'delay' cycles (with stray start/in_valid), then hand it off
  task automatic finish_txn(input int delay);
    for (int d = 0; d < delay; d++) begin
      result_ready_i = 1'b0;
      start_i = 1'b1;
      in_valid_i = 1'b1;
      in_bit_i = 1'b1;
      tick();
      check_busy("hold");
    end
    start_i = 1'b0;
    in_valid_i = 1'b0;
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    check_idle("handoff", m_ones, m_ones);
  endtask

  initial begin
    // Power-on reset
    tick();
    check_idle("por", 0, W);
    reset = 1'b1;
    tick();
    check_idle("por_rel", 0, W);

    // All ones, back to back
    start_txn(0);
    for (int i = 0; i < W; i++) send_bit(1'b1, 0);
    check("ones_result", int'(result_o), 32);
    check("ones_upper", int'(upper_bound_o), 32);
    finish_txn(0);

    // Alternating 1,0: fixed mid-stream bounds after 10 bits
    start_txn(16);
    for (int i = 0; i < W; i++) begin
      send_bit(((i % 2) == 0) ? 1'b1 : 1'b0, 0);
      if (i == 9) begin
        check("alt10_lower", int'(lower_bound_o), 5);
        check("alt10_upper", int'(upper_bound_o), 27);
      end
    end
    check("alt_result", int'(result_o), 16);
    finish_txn(0);

    // Zeros with in_valid low every third cycle
    start_txn(1);
    for (int i = 0; i < W; i++) send_bit(1'b0, ((i % 2) == 1) ? 1 : 0);
    check("zeros_result", int'(result_o), 0);
    finish_txn(0);

    // Result held for 5 stalled cycles with start noise, then handed off
    start_txn(20);
    for (int i = 0; i < W; i++) send_bit(1'($urandom), 0);
    finish_txn(5);

    // Start coinciding with the handshake is ignored; the following start is taken
    start_txn(3);
    for (int i = 0; i < W; i++) send_bit(1'b1, 0);
    start_i = 1'b1;
    result_ready_i = 1'b1;
    tick();
    start_i = 1'b0;
    result_ready_i = 1'b0;
    check_idle("hs_start", 32, 32);

    // Reset mid-stream after 12 bits, then a fresh stream of seven ones
    start_txn(8);
    for (int i = 0; i < 12; i++) send_bit(1'b1, 0);
    reset = 1'b0;
    #1;
    check_idle("midrst", 0, W);
    tick();
    reset = 1'b1;
    tick();
    check_idle("midrst_rel", 0, W);
    start_txn(8);
    for (int i = 0; i < W; i++) send_bit((i < 7) ? 1'b1 : 1'b0, 0);
    check("seven_result", int'(result_o), 7);
    finish_txn(1);

    // Threshold resolution cases
    start_txn(30);
    for (int i = 0; i < W; i++) send_bit((i < 3) ? 1'b0 : 1'b1, 0);
    finish_txn(0);

    // Random streams, gaps, thresholds and stall lengths
    for (int t = 0; t < 20; t++) begin
      start_txn(int'($urandom_range(0, W)));
      for (int i = 0; i < W; i++) send_bit(1'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0);
      finish_txn(int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
